// File: rtl/adder_pkg.sv
// Shared types and constants for the digit-serial adder and its nibble slice.
package adder_pkg;

    localparam int unsigned DIGIT = 4;

    typedef struct packed {
        logic c_t;
        logic c_f;
    } carry_dr_t;

    localparam carry_dr_t CARRY_ZERO = 2'b01;
    localparam carry_dr_t CARRY_ONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Dual-rail to binary; the illegal pairs 00/11 resolve to 0.
    function automatic logic carry_bit(input carry_dr_t c);
        return c.c_t & ~c.c_f;
    endfunction

    function automatic logic carry_illegal(input carry_dr_t c);
        return c.c_t ~^ c.c_f;
    endfunction

endpackage

// File: rtl/adder_digit_serial_if.sv
// Operand/result handshake bundle for adder_digit_serial.
// carry_err exists only when ADDER_CARRY_CHECK_EN is defined.
interface adder_digit_serial_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef ADDER_CARRY_CHECK_EN
    logic             carry_err;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, carry_err
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, carry_err
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/adder_nibble_slice.sv
// Exact 4-bit adder slice with dual-rail carry in/out; an approximate
// slice with the same ports can replace it without touching control.
module adder_nibble_slice
    import adder_pkg::*;
(
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  carry_dr_t        cin,
    output logic [DIGIT-1:0] sum,
    output carry_dr_t        cout
);

    logic [DIGIT:0] total;

    assign total = (DIGIT+1)'(a) + (DIGIT+1)'(b) + (DIGIT+1)'(carry_bit(cin));
    assign sum   = total[DIGIT-1:0];
    assign cout  = total[DIGIT] ? CARRY_ONE : CARRY_ZERO;

endmodule

// File: rtl/adder_digit_serial.sv
// Digit-serial WIDTH-bit adder: one nibble per cycle through a shared slice,
// dual-rail carry held between cycles. Optional carry_err via ADDER_CARRY_CHECK_EN.
module adder_digit_serial
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    adder_digit_serial_if.slave bus
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    carry_dr_t        carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             cout_q, cout_d;
    logic             accept_c;

    logic [DIGIT-1:0] slice_sum;
    carry_dr_t        slice_cout;

    adder_nibble_slice u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // in_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign accept_c = bus.in_valid & in_ready_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    carry_d    = '{c_t: bus.in_cin, c_f: ~bus.in_cin};
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIG) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = carry_bit(slice_cout);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= CARRY_ZERO;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

`ifdef ADDER_CARRY_CHECK_EN
    logic err_q, err_d;

    // Sticky flag for an illegal carry pair; a fresh accept starts it clean.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && accept_c) begin
            err_d = 1'b0;
        end else if (state_q != IDLE && carry_illegal(carry_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.carry_err = err_q;
`endif

endmodule

// File: tb/tb_adder_digit_serial.sv
// Scoreboard bench for adder_digit_serial: directed vectors push expected results,
// an independent monitor pops and compares on each presented result.
module tb_adder_digit_serial;
    import adder_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NDIG  = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_digit_serial_if #(.WIDTH(WIDTH)) bus ();

    adder_digit_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0 at %0t", $time);
            end else begin
                if (!seen_valid) begin
                    // accept edge read the pre-increment count, so this is N+1
                    check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(NDIG + 1));
                    seen_valid = 1'b1;
                end
                check("out_sum", 64'(bus.out_sum), 64'(exp_q[0].sum));
                check("out_cout", 64'(bus.out_cout), 64'(exp_q[0].cout));
                check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] es, input logic ec);
        int budget = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{es, ec, cyc});
        #1;
        // Busy-time junk on the input side must be ignored.
        bus.in_a   = ~a;
        bus.in_b   = 32'h5555_5555;
        bus.in_cin = ~cin;
    endtask

    task automatic wait_valid();
        int budget = 0;
        while (!bus.out_valid && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic wait_done();
        int budget = 0;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end else begin
            check("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
            check("out_valid_after_handshake", 64'(bus.out_valid), 64'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_sum"}, 64'(bus.out_sum), 64'd0);
        check({tag, "_out_cout"}, 64'(bus.out_cout), 64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("reset");

        send(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0);
        wait_done();
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        wait_done();
        send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1);
        wait_done();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
        wait_done();
        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hF0E2_1567, 1'b0);
        wait_done();

        // Consumer stall: result must hold and in_ready stay low until the handshake.
        bus.out_ready = 1'b0;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        bus.in_valid = 1'b0;
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        wait_done();

        // Reset during RUN cycle 4 discards the partial result.
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        seen_valid   = 1'b0;
        #2;
        check_reset_values("midrun_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("post_reset");
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        wait_done();

`ifdef ADDER_CARRY_CHECK_EN
        check("carry_err_clean", 64'(bus.carry_err), 64'd0);
        bus.out_ready = 1'b0;
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        force dut.slice_cout = carry_dr_t'(2'b11);
        @(posedge clk);
        #1;
        release dut.slice_cout;
        bus.in_valid = 1'b0;
        wait_valid();
        check("carry_err_done", 64'(bus.carry_err), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("carry_err_sticky", 64'(bus.carry_err), 64'd1);
        bus.out_ready = 1'b1;
        wait_done();
        check("carry_err_idle", 64'(bus.carry_err), 64'd1);
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0);
        check("carry_err_cleared", 64'(bus.carry_err), 64'd0);
        wait_done();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
